hit_sfx_mixer: RTL and testbench
================================

Name: hit_sfx_mixer

Overview:
Sample-rate stage between the music waveform generator and the speaker/I2S controller. On a rising edge of hit, it synthesises a square-wave tone burst with an attack/decay envelope. It adds the burst to the 16-bit signed music sample with saturation and presents the mixed sample to the speaker controller's left and right inputs. With no hit activity the music passes through unchanged.

Parameters:
SAMPLE_DIV, 2048, clk cycles per sample tick (>=2)
TONE_HALF, 24, sample ticks per square-wave half-period (>=1)
SFX_PEAK, 8192, tone amplitude at full envelope (signed 16-bit, positive)
ATTACK_STEP, 16, envelope increment per sample tick in ATTACK
DECAY_STEP, 1, envelope decrement per decay step
DECAY_TICKS, 16, sample ticks per decay step (>=1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
hit  input  1  sound-effect trigger, clk-synchronous level; rising edge fires
en_sfx  input  1  effect enable; 0 forces effect off
music_in  input  16  signed music sample
mix_out  output  16  signed mixed sample to speaker controller
sample_tick  output  1  one-cycle pulse when mix_out updates
sfx_busy  output  1  high while state != IDLE

Behaviour:
- Reset (rst=0, asynchronous): mix_out=0, sample_tick=0, sfx_busy=0, state=IDLE, env=0, phase=0, all counters=0, hit_d=0.
- Sample counter:
  - Counts 0..SAMPLE_DIV-1 and wraps.
  - The internal tick is high in the cycle where count==SAMPLE_DIV-1.
  - sample_tick is a registered copy of the internal tick.
- Trigger: fire = hit & ~hit_d & en_sfx, evaluated every clk cycle and not only on ticks. Holding hit high triggers once.
- Envelope: env is 9-bit unsigned, range 0..256. FSM states:
  - IDLE: env=0, phase=0, tone and decay counters=0. On fire: go to ATTACK.
  - ATTACK: on each tick, env=min(env+ATTACK_STEP, 256). When env reaches 256: go to DECAY.
  - DECAY: a decay counter counts ticks. Every DECAY_TICKS ticks, env=max(env-DECAY_STEP, 0). When env reaches 0: go to IDLE.
- Retrigger: fire in ATTACK or DECAY goes to ATTACK. env keeps its current value (no discontinuity). The phase and tone counter continue. The decay counter clears.
- en_sfx=0 in any state: on the next edge, state=IDLE, env=0, phase=0. This takes priority over fire.
- Tone generation (not IDLE): a tone counter advances on each tick. phase toggles every TONE_HALF ticks.
- sfx value:
  - sfx = (phase ? -SFX_PEAK : +SFX_PEAK) * env, as a 26-bit signed product.
  - The product is then arithmetically shifted right by 8.
  - env=256 therefore gives exactly ±SFX_PEAK.
- Mixing, on a tick edge:
  - mix_out <= sat16(sign-extended music_in + sfx), where the sum is 17 bits.
  - Saturation limits are 32767 and -32768.
  - sfx uses the env and phase values from before that edge's update. Env/phase updates happen on the same edge.
- Latency: music_in sampled in the internal-tick cycle appears on mix_out one cycle later, coincident with sample_tick=1. Between ticks, mix_out holds its value.
- sfx_busy is registered and reflects the state after each edge.
- Simultaneous events: fire and tick in the same cycle means the state goes to ATTACK on that edge. The mixed sample uses the pre-edge env.

Decomposition:
- audio_pkg holds:
  - AUDIO_W=16
  - SAT_MAX=16'sh7FFF and SAT_MIN=16'sh8000
  - ENV_W=9 and ENV_FULL=256
  - the FSM state typedef (IDLE, ATTACK, DECAY)
- Sub-module sfx_envelope contains the FSM, env, decay counter, tone counter and phase. Its outputs are env, phase and busy.
- The top level keeps the sample counter, the edge detect, the multiply/shift and the saturating add.

Test Plan:
Unless stated, benches use SAMPLE_DIV=4, TONE_HALF=2, SFX_PEAK=8192, ATTACK_STEP=64, DECAY_STEP=32, DECAY_TICKS=1.
1. Passthrough: music_in=1000, no hit -> sample_tick pulses every 4 cycles; mix_out=1000 at each pulse; sfx_busy=0.
2. Burst:
   - Stimulus: music_in=0, single hit pulse.
   - |mix_out| over successive ticks is 0, 2048, 4096, 6144, 8192, then steps of 1024 down to 0.
   - Sign flips every 2 ticks, starting positive.
   - sfx_busy falls after env reaches 0.
3. Saturation, at env=256:
   - music_in=32000 with phase=0 -> mix_out=32767.
   - music_in=-32000 with phase=1 -> mix_out=-32768.
   - music_in=-8192 with phase=0 -> mix_out=0.
4. Retrigger: hit in DECAY at env=128 -> ATTACK; env goes 192 then 256; no zero-sample glitch on mix_out. hit held high for 20 cycles produces only one trigger.
5. Disable: en_sfx=0 mid-DECAY -> sfx_busy=0 next cycle; next mix_out equals music_in. A hit while en_sfx=0 has no effect.
6. Reset mid-burst: rst=0 asynchronously during ATTACK -> all outputs 0 without waiting for a clk edge. After release, the first sample_tick occurs 4 cycles later and the state is IDLE.

Source files
------------

// File: rtl/audio_pkg.sv
// audio_pkg: shared sample widths, saturation limits and envelope FSM states
package audio_pkg;
   localparam int AUDIO_W = 16;
   localparam logic signed [AUDIO_W-1:0] SAT_MAX = 16'sh7FFF;
   localparam logic signed [AUDIO_W-1:0] SAT_MIN = 16'sh8000;
   localparam int ENV_W = 9;
   localparam logic [ENV_W-1:0] ENV_FULL = 9'd256;
   typedef enum logic [1:0] {IDLE, ATTACK, DECAY} state_t;
endpackage

// File: rtl/sfx_envelope.sv
// sfx_envelope: attack/decay envelope FSM plus square-wave phase for the hit burst
module sfx_envelope
   import audio_pkg::*;
#(
   parameter int TONE_HALF   = 24,
   parameter int ATTACK_STEP = 16,
   parameter int DECAY_STEP  = 1,
   parameter int DECAY_TICKS = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             fire,
   input  logic             en_sfx,
   output logic [ENV_W-1:0] env,
   output logic             phase,
   output logic             busy
);
   localparam int TW = $clog2(TONE_HALF + 1);
   localparam int DW = $clog2(DECAY_TICKS + 1);
   state_t state, state_n;
   logic [ENV_W-1:0] env_n, env_dn;
   logic [ENV_W:0] env_up;
   logic [TW-1:0] tcnt, tcnt_n;
   logic [DW-1:0] dcnt, dcnt_n;
   logic phase_n, tone_wrap, decay_due;
   assign tone_wrap = tcnt == TW'(TONE_HALF - 1);
   assign decay_due = dcnt == DW'(DECAY_TICKS - 1);
   assign env_up    = {1'b0, env} + (ENV_W+1)'(ATTACK_STEP);
   assign env_dn    = env > ENV_W'(DECAY_STEP) ? env - ENV_W'(DECAY_STEP) : '0;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         env   <= '0;
         tcnt  <= '0;
         dcnt  <= '0;
         phase <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_n;
         env   <= env_n;
         tcnt  <= tcnt_n;
         dcnt  <= dcnt_n;
         phase <= phase_n;
         busy  <= state_n != IDLE;
      end
   // the tone keeps running through a retrigger so the waveform stays continuous
   always_comb begin
      state_n = state;
      env_n   = env;
      tcnt_n  = tcnt;
      dcnt_n  = dcnt;
      phase_n = phase;
      if (tick && state != IDLE) begin
         tcnt_n  = tone_wrap ? '0 : tcnt + 1'b1;
         phase_n = phase ^ tone_wrap;
      end
      if (!en_sfx) begin
         state_n = IDLE;
         env_n   = '0;
         tcnt_n  = '0;
         dcnt_n  = '0;
         phase_n = 1'b0;
      end else if (fire) begin
         state_n = ATTACK;
         dcnt_n  = '0;
      end else if (tick && state == ATTACK) begin
         env_n   = env_up >= {1'b0, ENV_FULL} ? ENV_FULL : env_up[ENV_W-1:0];
         state_n = env_n == ENV_FULL ? DECAY : ATTACK;
      end else if (tick && state == DECAY) begin
         dcnt_n = decay_due ? '0 : dcnt + 1'b1;
         env_n  = decay_due ? env_dn : env;
         if (decay_due && env_dn == '0) begin
            state_n = IDLE;
            tcnt_n  = '0;
            phase_n = 1'b0;
         end
      end
   end
endmodule

// File: rtl/hit_sfx_mixer.sv
// hit_sfx_mixer: mixes a hit-triggered enveloped square-wave burst into the music
// stream at the sample rate, saturating to 16 bits
module hit_sfx_mixer
   import audio_pkg::*;
#(
   parameter int SAMPLE_DIV  = 2048,
   parameter int TONE_HALF   = 24,
   parameter int SFX_PEAK    = 8192,
   parameter int ATTACK_STEP = 16,
   parameter int DECAY_STEP  = 1,
   parameter int DECAY_TICKS = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      hit,
   input  logic                      en_sfx,
   input  logic signed [AUDIO_W-1:0] music_in,
   output logic signed [AUDIO_W-1:0] mix_out,
   output logic                      sample_tick,
   output logic                      sfx_busy
);
   localparam int CW = $clog2(SAMPLE_DIV);
   logic [CW-1:0] cnt;
   logic tick, hit_d, fire, phase;
   logic [ENV_W-1:0] env;
   logic signed [25:0] amp, prod;
   logic signed [AUDIO_W:0] sfx, sum;
   logic signed [AUDIO_W-1:0] sat;
   assign tick = cnt == CW'(SAMPLE_DIV - 1);
   assign fire = hit & ~hit_d & en_sfx;
   // env is 0..256 so the >>>8 scales the peak by env/256
   assign amp  = phase ? -26'(SFX_PEAK) : 26'(SFX_PEAK);
   assign prod = amp * $signed({{(26-ENV_W){1'b0}}, env});
   assign sfx  = (AUDIO_W+1)'(prod >>> 8);
   assign sum  = (AUDIO_W+1)'(music_in) + sfx;
   assign sat  = sum[AUDIO_W] != sum[AUDIO_W-1] ? (sum[AUDIO_W] ? SAT_MIN : SAT_MAX) : sum[AUDIO_W-1:0];
   sfx_envelope #(
      .TONE_HALF  (TONE_HALF),
      .ATTACK_STEP(ATTACK_STEP),
      .DECAY_STEP (DECAY_STEP),
      .DECAY_TICKS(DECAY_TICKS)
   ) u_env (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .fire  (fire),
      .en_sfx(en_sfx),
      .env   (env),
      .phase (phase),
      .busy  (sfx_busy)
   );
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         cnt         <= '0;
         hit_d       <= 1'b0;
         sample_tick <= 1'b0;
         mix_out     <= '0;
      end else begin
         cnt         <= tick ? '0 : cnt + 1'b1;
         hit_d       <= hit;
         sample_tick <= tick;
         if (tick) mix_out <= sat;
      end
endmodule

// File: tb/tb_hit_sfx_mixer.sv
// tb_hit_sfx_mixer: directed vector table plus hand sequences for retrigger, disable and reset
module tb_hit_sfx_mixer;
   logic clk, rst, hit, en_sfx, sample_tick, sfx_busy;
   logic signed [15:0] music_in, mix_out;
   int checks = 0;
   int fails  = 0;

   typedef struct {
      logic signed [15:0] music;
      logic               hit;
      logic signed [15:0] mix;
      logic               busy;
   } vec_t;
   vec_t vecs[$];

   hit_sfx_mixer #(
      .SAMPLE_DIV (4),
      .TONE_HALF  (2),
      .SFX_PEAK   (8192),
      .ATTACK_STEP(64),
      .DECAY_STEP (32),
      .DECAY_TICKS(1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .hit        (hit),
      .en_sfx     (en_sfx),
      .music_in   (music_in),
      .mix_out    (mix_out),
      .sample_tick(sample_tick),
      .sfx_busy   (sfx_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic add(input int m, input bit h, input int x, input bit b);
      vec_t v;
      v.music = 16'(m);
      v.hit   = h;
      v.mix   = 16'(x);
      v.busy  = b;
      vecs.push_back(v);
   endtask

   task automatic wait_tick(output int n);
      n = 0;
      do begin
         @(negedge clk);
         hit = 1'b0;
         n++;
      end while (!sample_tick && n < 8);
      if (!sample_tick) begin
         checks++;
         fails++;
         $display("FAIL tick_timeout actual=no_tick expected=tick within 8 cycles");
      end
   endtask

   initial begin
      int n, nt;
      // passthrough
      repeat (3) add(1000, 0, 1000, 0);
      // single burst from idle
      add(0, 1, 0, 1);     add(0, 0, 2048, 1);  add(0, 0, -4096, 1); add(0, 0, -6144, 1);
      add(0, 0, 8192, 1);  add(0, 0, 7168, 1);  add(0, 0, -6144, 1); add(0, 0, -5120, 1);
      add(0, 0, 4096, 1);  add(0, 0, 3072, 1);  add(0, 0, -2048, 1); add(0, 0, -1024, 0);
      add(0, 0, 0, 0);
      // burst with positive saturation, retrigger at env=128, negative saturation
      add(0, 1, 0, 1);     add(0, 0, 2048, 1);  add(0, 0, -4096, 1); add(0, 0, -6144, 1);
      add(32000, 0, 32767, 1);                  add(0, 0, 7168, 1);  add(0, 0, -6144, 1);
      add(0, 0, -5120, 1); add(0, 1, 4096, 1);  add(0, 0, 6144, 1);
      add(-32000, 0, -32768, 1);                add(0, 0, -7168, 1); add(0, 0, 6144, 1);
      add(0, 0, 5120, 1);  add(0, 0, -4096, 1); add(0, 0, -3072, 1); add(0, 0, 2048, 1);
      add(0, 0, 1024, 0);  add(0, 0, 0, 0);
      // burst cancelling music exactly at full envelope
      add(0, 1, 0, 1);     add(0, 0, 2048, 1);  add(0, 0, -4096, 1); add(0, 0, -6144, 1);
      add(-8192, 0, 0, 1);

      rst = 1'b0; hit = 1'b0; en_sfx = 1'b1; music_in = 16'sd1000;
      #12;
      chk("reset_mix", mix_out, 0);
      chk("reset_tick", sample_tick, 0);
      chk("reset_busy", sfx_busy, 0);
      @(negedge clk);
      rst = 1'b1;

      foreach (vecs[i]) begin
         music_in = vecs[i].music;
         hit      = vecs[i].hit;
         wait_tick(n);
         chk($sformatf("row%0d_gap", i), n, 4);
         chk($sformatf("row%0d_mix", i), mix_out, vecs[i].mix);
         chk($sformatf("row%0d_busy", i), sfx_busy, vecs[i].busy);
      end

      // disable mid-decay
      music_in = 16'sd500;
      en_sfx   = 1'b0;
      @(negedge clk);
      chk("dis_busy_next", sfx_busy, 0);
      wait_tick(n);
      chk("dis_mix", mix_out, 500);
      // hit while disabled must not arm anything
      hit = 1'b1;
      @(negedge clk);
      hit = 1'b0;
      @(negedge clk);
      en_sfx = 1'b1;
      wait_tick(n);
      chk("dis_hit_mix1", mix_out, 500);
      wait_tick(n);
      chk("dis_hit_mix2", mix_out, 500);
      chk("dis_hit_busy", sfx_busy, 0);

      // hit held for 20 cycles triggers once
      music_in = 16'sd0;
      hit = 1'b1;
      nt = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (sample_tick) nt++;
      end
      hit = 1'b0;
      chk("hold_ticks", nt, 5);
      chk("hold_peak", mix_out, 8192);
      wait_tick(n);
      chk("hold_decay", mix_out, 7168);

      // async reset during attack
      music_in = 16'sd777;
      hit = 1'b1;
      @(negedge clk);
      hit = 1'b0;
      chk("rst_pre_busy", sfx_busy, 1);
      #2 rst = 1'b0;
      #1;
      chk("arst_mix", mix_out, 0);
      chk("arst_tick", sample_tick, 0);
      chk("arst_busy", sfx_busy, 0);
      @(negedge clk);
      rst = 1'b1;
      wait_tick(n);
      chk("arst_gap", n, 4);
      chk("arst_mix1", mix_out, 777);
      chk("arst_busy1", sfx_busy, 0);
      wait_tick(n);
      chk("arst_mix2", mix_out, 777);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
